// File: rtl/cic_comp_pkg.sv
// Shared constants, FSM state type and coefficient table for the post-CIC
// compensation FIR and its output stages.
package cic_comp_pkg;

  localparam int DATA_W        = 16;
  localparam int NTAPS         = 7;
  localparam int DECIM_DEFAULT = 2;
  localparam int COEF_W        = 12;
  localparam int COEF_FRAC     = 10;
  localparam int ACC_W         = 32;
  localparam int TAP_W         = $clog2(NTAPS);
  localparam int PROD_W        = DATA_W + COEF_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Symmetric 7-tap table, sums to 1024 (unity DC gain at COEF_FRAC=10).
  function automatic logic signed [COEF_W-1:0] coef(input logic [TAP_W-1:0] k);
    case (k)
      3'd0, 3'd6: coef = -12'sd32;
      3'd2, 3'd4: coef = 12'sd288;
      3'd3:       coef = 12'sd512;
      default:    coef = '0;
    endcase
  endfunction

endpackage

// File: rtl/round_sat.sv
// Combinational round-half-up and clamp from the accumulator width down to
// a DATA_W signed sample.
module round_sat
  import cic_comp_pkg::*;
(
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] y
);

  localparam logic signed [ACC_W-1:0] HALF  = ACC_W'(1 << (COEF_FRAC - 1));
  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] MIN_V = -MAX_V - ACC_W'(1);

  logic signed [ACC_W-1:0] rounded;

  always_comb begin
    rounded = (acc + HALF) >>> COEF_FRAC;
    if (rounded > MAX_V) begin
      y = MAX_V[DATA_W-1:0];
    end else if (rounded < MIN_V) begin
      y = MIN_V[DATA_W-1:0];
    end else begin
      y = rounded[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/cic_comp_fir.sv
// Post-CIC compensation FIR: 7-tap symmetric filter on one time-shared MAC,
// decimating by DECIM with rounded, saturated 16-bit output.
module cic_comp_fir
  import cic_comp_pkg::*;
#(
  parameter int DECIM = DECIM_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     overrun,
  output state_t                   fsm_state
);

  localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  // Handshake: a sample transfers on a clock edge where in_valid && in_ready;
  // in_valid with in_ready low drops the sample and sets the sticky overrun.
  state_t                   state;
  state_t                   state_nxt;
  logic [TAP_W-1:0]         tap;
  logic [PH_W-1:0]          phase;
  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W-1:0] x [NTAPS];
  logic signed [PROD_W-1:0] prod;
  logic signed [DATA_W-1:0] sat_data;
  logic                     accept;
  logic                     trigger;

  assign accept  = in_valid && in_ready;
  assign trigger = accept && (phase == PH_W'(DECIM - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trigger) state_nxt = MAC;
      MAC:     if (tap == TAP_W'(NTAPS - 1)) state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    fsm_state = state;
  end

  always_comb begin
    prod = PROD_W'(coef(tap)) * PROD_W'(x[tap]);
  end

  round_sat u_round_sat (
    .acc (acc),
    .y   (sat_data)
  );

  // Delay line only moves on accepts, so it is naturally frozen during MAC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      overrun   <= 1'b0;
      acc       <= '0;
      tap       <= '0;
      phase     <= '0;
      for (int k = 0; k < NTAPS; k++) x[k] <= '0;
    end else begin
      out_valid <= (state == OUT);
      if (state == OUT) out_data <= sat_data;
      if (in_valid && !in_ready) overrun <= 1'b1;
      if (accept) begin
        x[0] <= in_data;
        for (int k = 1; k < NTAPS; k++) x[k] <= x[k-1];
        phase <= (phase == PH_W'(DECIM - 1)) ? '0 : phase + 1'b1;
      end
      if (trigger) begin
        acc <= '0;
        tap <= '0;
      end else if (state == MAC) begin
        acc <= acc + ACC_W'(prod);
        tap <= tap + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cic_comp_fir.sv
// Self-checking bench for cic_comp_fir against a sliding-window reference
// built from the accepted-sample history.
module tb_cic_comp_fir;
  import cic_comp_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic signed [15:0] in_data;
  logic               in_ready;
  logic               out_valid;
  logic signed [15:0] out_data;
  logic               overrun;
  state_t             fsm_state;

  int checks = 0;
  int fails  = 0;
  int hist[$];
  int n_acc  = 0;
  int coefs[7] = '{-32, 0, 288, 512, 288, 0, -32};

  always #5 clk = ~clk;

  cic_comp_fir dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .overrun   (overrun),
    .fsm_state (fsm_state)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog expired");
  end

  // y = round_half_up(sum C[k]*x[n-k] / 1024), clamped to 16-bit signed.
  function automatic int model_out();
    longint s = 0;
    for (int k = 0; k < 7; k++) begin
      int idx = hist.size() - 1 - k;
      if (idx >= 0) s += longint'(coefs[k]) * longint'(hist[idx]);
    end
    s = (s + 512) >>> 10;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return int'(s);
  endfunction

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    repeat (cycles) @(posedge clk);
    #1 reset = 1'b0;
    hist.delete();
    n_acc = 0;
  endtask

  task automatic put(input int v, output bit trig, output logic signed [15:0] expv);
    int t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      checks++; fails++;
      $display("FAIL put_ready_timeout: in_ready=%0b required 1", in_ready);
    end
    in_valid = 1'b1;
    in_data = 16'(v);
    @(posedge clk); #1;
    in_valid = 1'b0;
    hist.push_back(v);
    n_acc++;
    trig = (n_acc % 2 == 0);
    expv = 16'(model_out());
  endtask

  task automatic wait_out(output int cyc, output bit seen);
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      seen = out_valid;
    end
  endtask

  task automatic test_reset();
    do_reset(3);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    checks++; if (out_data !== 16'sd0) begin fails++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %0b expected 0", overrun); end
  endtask

  task automatic test_dc_step();
    bit trig, seen;
    int cyc, outs;
    logic signed [15:0] expv, last;
    do_reset(2);
    outs = 0;
    last = '0;
    for (int i = 0; i < 20; i++) begin
      put(1000, trig, expv);
      if (trig) begin
        wait_out(cyc, seen);
        outs++;
        last = expv;
        checks++;
        if (!seen || out_data !== expv) begin
          fails++; $display("FAIL dc_out[%0d]: got %0d (valid %0b) expected %0d", outs, out_data, seen, expv);
        end
        if (outs == 1) begin
          checks++;
          if (cyc != 8) begin fails++; $display("FAIL dc_latency: got %0d cycles expected 8", cyc); end
        end
        if (outs >= 4) begin
          checks++;
          if (out_data !== 16'sd1000) begin fails++; $display("FAIL dc_settled[%0d]: got %0d expected 1000", outs, out_data); end
        end
      end else begin
        repeat (3) @(posedge clk);
        #1;
      end
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL dc_strobe_width: out_valid got %0b expected 0", out_valid); end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (out_data !== last) begin fails++; $display("FAIL dc_hold: got %0d expected %0d", out_data, last); end
  endtask

  task automatic test_impulse();
    bit trig, seen;
    int cyc, j;
    logic signed [15:0] expv;
    int imp[8]  = '{1024, 0, 0, 0, 0, 0, 0, 0};
    int want[4] = '{0, 512, 0, 0};
    do_reset(2);
    j = 0;
    for (int i = 0; i < 8; i++) begin
      put(imp[i], trig, expv);
      if (trig) begin
        wait_out(cyc, seen);
        checks++;
        if (!seen || out_data !== 16'(want[j])) begin
          fails++; $display("FAIL impulse[%0d]: got %0d (valid %0b) expected %0d", j, out_data, seen, want[j]);
        end
        j++;
      end else begin
        repeat (3) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_saturation();
    bit trig, seen;
    int cyc, edge_v, mid_v, want, v;
    logic signed [15:0] expv;
    do_reset(2);
    for (int p = 0; p < 2; p++) begin
      edge_v = (p == 0) ? -32768 : 32767;
      mid_v  = (p == 0) ? 32767 : -32768;
      want   = (p == 0) ? 32767 : -32768;
      for (int i = 0; i < 8; i++) begin
        v = (i == 0) ? 0 : ((i == 1 || i == 7) ? edge_v : mid_v);
        put(v, trig, expv);
        if (trig) begin
          wait_out(cyc, seen);
          checks++;
          if (!seen || out_data !== expv) begin
            fails++; $display("FAIL sat_model[%0d.%0d]: got %0d (valid %0b) expected %0d", p, i, out_data, seen, expv);
          end
          if (i == 7) begin
            checks++;
            if (out_data !== 16'(want)) begin fails++; $display("FAIL sat_clamp[%0d]: got %0d expected %0d", p, out_data, want); end
          end
        end
      end
    end
  endtask

  task automatic test_overrun();
    bit trig, seen;
    int cyc;
    logic signed [15:0] expv;
    do_reset(2);
    put(100, trig, expv);
    put(200, trig, expv);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data = 16'sd12345;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin fails++; $display("FAIL overrun_set: got %0b expected 1", overrun); end
    wait_out(cyc, seen);
    checks++;
    if (!seen || out_data !== expv) begin fails++; $display("FAIL overrun_out0: got %0d (valid %0b) expected %0d", out_data, seen, expv); end
    put(300, trig, expv);
    put(400, trig, expv);
    wait_out(cyc, seen);
    checks++;
    if (!seen || out_data !== expv) begin fails++; $display("FAIL overrun_out1: got %0d (valid %0b) expected %0d", out_data, seen, expv); end
    checks++;
    if (overrun !== 1'b1) begin fails++; $display("FAIL overrun_sticky: got %0b expected 1", overrun); end
  endtask

  task automatic test_reset_mid_mac();
    bit trig, seen, any;
    int cyc;
    logic signed [15:0] expv;
    trig = 1'b0;
    while (!trig) put(int'($urandom_range(1000, 9000)), trig, expv);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midmac_out_valid: got %0b expected 0", out_valid); end
    checks++; if (out_data !== 16'sd0) begin fails++; $display("FAIL midmac_out_data: got %0d expected 0", out_data); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL midmac_in_ready: got %0b expected 1", in_ready); end
    checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL midmac_overrun: got %0b expected 0", overrun); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    hist.delete();
    n_acc = 0;
    any = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      any |= out_valid;
    end
    checks++;
    if (any) begin fails++; $display("FAIL midmac_aborted: out_valid got 1 expected 0"); end
    put(700, trig, expv);
    any = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      any |= out_valid;
    end
    checks++;
    if (any) begin fails++; $display("FAIL midmac_first_sample: out_valid got 1 expected 0"); end
    put(800, trig, expv);
    wait_out(cyc, seen);
    checks++;
    if (!seen || cyc != 8 || out_data !== expv) begin
      fails++; $display("FAIL midmac_resume: got %0d after %0d cycles expected %0d after 8", out_data, cyc, expv);
    end
  endtask

  task automatic test_random();
    bit trig, seen;
    int cyc, v;
    logic signed [15:0] expv;
    do_reset(2);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) v = int'($urandom_range(0, 2000)) - 1000;
      else v = int'($urandom_range(0, 65535)) - 32768;
      put(v, trig, expv);
      if (trig) begin
        wait_out(cyc, seen);
        checks++;
        if (!seen || cyc != 8 || out_data !== expv) begin
          fails++; $display("FAIL random[%0d]: got %0d after %0d cycles expected %0d after 8", i, out_data, cyc, expv);
        end
      end else begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    test_reset();
    test_dc_step();
    test_impulse();
    test_saturation();
    test_overrun();
    test_reset_mid_mac();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
